fft_bitrev_reorder: RTL



---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_pingpong_ram.sv | 54 +++++
 rtl/fft_bitrev_reorder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the radix-2 FFT pipeline.
//
// Contents:
//   N_DEFAULT / DW_DEFAULT : default FFT length and component width
//   AW_DEFAULT             : bank/stage address width derived from N_DEFAULT
//   sample_t               : one complex sample, {re, im}
//   bitrev()               : reverse the low w bits of an address; shared by
//                            the reorder buffer and the stage address logic
package fft_pkg;

  localparam int N_DEFAULT   = 32;
  localparam int DW_DEFAULT  = 16;
  localparam int AW_DEFAULT  = $clog2(N_DEFAULT);

  // Widest address bitrev() handles; callers zero-extend into this width.
  localparam int BITREV_MAXW = 16;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] re;
    logic [DW_DEFAULT-1:0] im;
  } sample_t;

  // Bit i of the input lands on bit w-1-i of the result; bits at or above w
  // are returned as zero. w must be a constant at the call site.
  function automatic logic [BITREV_MAXW-1:0] bitrev(
    input logic [BITREV_MAXW-1:0] a,
    input int unsigned            w
  );
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAXW; i++) begin
      if (i < int'(w)) begin
        r[int'(w) - 1 - i] = a[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram -- two-bank sample store for the reorder buffer.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset (clears the read register only)
//   wr_en_i    : write strobe
//   wr_bank_i  : bank selected for the write
//   wr_addr_i  : word address within the write bank
//   wr_data_i  : word to store
//   rd_en_i    : load the read register from {rd_bank_i, rd_addr_i}
//   rd_bank_i  : bank selected for the read
//   rd_addr_i  : word address within the read bank
//   rd_data_o  : registered read data, held while rd_en_i is low
//
// The array has no reset so it maps onto block RAM; only the output
// register is reset, which block RAM output registers support.
module fft_pingpong_ram #(
  parameter int AW = 5,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  localparam int DEPTH = 2 * (1 << AW);

  logic [W-1:0] mem_q [0:DEPTH-1];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder -- output reorder buffer for the radix-2 FFT.
//
// Samples arrive in bit-reversed bin order and are written at a natural
// counter address; they are read back at bit-reversed addresses so the
// consumer sees natural bin order. Two banks ping-pong so one frame can be
// written while the previous one is read, sustaining one sample per cycle.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : in_data holds a sample
//   in_ready  : buffer can accept a sample (depends on registers only)
//   in_data   : sample {re, im}
//   out_valid : out_data holds a reordered sample
//   out_ready : consumer accepts out_data
//   out_data  : sample for the next natural bin index
//   out_last  : marks bin N-1 of a frame
//
// Optional build macro REORDER_OVERRUN_EN adds:
//   overrun   : sticky flag, in_valid seen while in_ready was low
//   frame_cnt : count of completed output frames (out_last handshakes), mod 256
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] out_data,
  output logic          out_last
`ifdef REORDER_OVERRUN_EN
  ,
  output logic          overrun,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int            AW       = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q, full_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          wr_fire;
  logic          adv;
  logic [AW-1:0] rd_addr;

  always_comb begin
    wr_fire     = in_valid && !full_q[wr_bank_q];
    // Load a new output word whenever the current one is absent or taken.
    adv         = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (wr_fire) begin
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // A set and a clear in the same cycle always hit different banks (the
    // writer never targets a full bank), so applying both is safe.
    if (adv) begin
      out_valid_d = 1'b1;
      out_last_d  = (rd_cnt_q == LAST_IDX);
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rd_addr = AW'(bitrev(BITREV_MAXW'(rd_cnt_q), AW));

  // The RAM read register doubles as the output data register: it only
  // loads on adv, so out_data is frozen while the consumer stalls.
  fft_pingpong_ram #(
    .AW (AW),
    .W  (2*DW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_data),
    .rd_en_i   (adv),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (out_data)
  );

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef REORDER_OVERRUN_EN
  logic       overrun_q;
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      if (in_valid && !in_ready) begin
        overrun_q <= 1'b1;
      end
      if (out_valid_q && out_ready && out_last_q) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;
`endif

endmodule
